aes_multiblock_fsm: RTL and testbench

- Parametrised next-generation AES HWPE control FSM; sits between the register-file slave, the plaintext source and ciphertext sink streamers, and the AES round engine.
- Sequences N consecutive 128-bit blocks per job, not a single fixed-length one.
- Supports AES-128/192/256 round counts and drives the engine round index explicitly.
- Signals job completion to the slave as a single-cycle done pulse.

---
 rtl/aes_multiblock_fsm_pkg.sv | 42 ++++
 rtl/aes_multiblock_fsm_round_counter.sv | 43 ++++
 rtl/aes_multiblock_fsm.sv | 216 +++++++++++++++++++++
 tb/tb_aes_multiblock_fsm.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_multiblock_fsm_pkg.sv
// ============================================================================
// Module : aes_package
// Brief  : Shared types and constants for the multi-block AES control FSM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_package;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STARTING = 3'd1,
    LOAD     = 3'd2,
    WORKING  = 3'd3,
    DRAIN    = 3'd4,
    FINISHED = 3'd5
  } aes_mb_state_t;

  typedef enum logic [1:0] {
    KEY_AES128 = 2'd0,
    KEY_AES192 = 2'd1,
    KEY_AES256 = 2'd2,
    KEY_RSVD   = 2'd3
  } aes_key_mode_t;

  localparam logic [3:0]  c_nr_aes128       = 4'd10;
  localparam logic [3:0]  c_nr_aes192       = 4'd12;
  localparam logic [3:0]  c_nr_aes256       = 4'd14;
  localparam int unsigned c_timeout_default = 1024;

  // The reserved key mode falls back to the AES-128 schedule.
  function automatic logic [3:0] nr_for_mode(input logic [1:0] mode);
    case (aes_key_mode_t'(mode))
      KEY_AES192: return c_nr_aes192;
      KEY_AES256: return c_nr_aes256;
      default:    return c_nr_aes128;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_multiblock_fsm_round_counter.sv
// ============================================================================
// Module : aes_round_counter
// Brief  : Round index for the AES engine; counts 0..NR while enabled.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en_i,
  input  logic [3:0] nr_i,
  output logic [3:0] round_o,
  output logic       last_o
);

  logic [3:0] round_cnt_q;
  logic [3:0] round_cnt_d;
  logic       w_last;

  assign w_last = en_i && (round_cnt_q == nr_i);

  // Falls back to zero whenever the engine is not in its round phase, so
  // every block starts from round 0 without an explicit load.
  assign round_cnt_d = (en_i && !w_last) ? round_cnt_q + 4'd1 : 4'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round_cnt_q <= 4'd0;
    end else if (clear) begin
      round_cnt_q <= 4'd0;
    end else begin
      round_cnt_q <= round_cnt_d;
    end
  end

  assign round_o = en_i ? round_cnt_q : 4'd0;
  assign last_o  = w_last;

endmodule

`default_nettype wire

// File: rtl/aes_multiblock_fsm.sv
// ============================================================================
// Module : aes_multiblock_fsm
// Brief  : Multi-block AES HWPE control FSM (streamers, engine, done pulse).
//          Optional watchdog enabled by defining AES_MBFSM_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_multiblock_fsm
  import aes_package::*;
#(
  parameter  int unsigned BUS_W          = 32,
  parameter  int unsigned CNT_W          = 16,
  parameter  int unsigned ADDR_W         = 32,
  parameter  int unsigned TIMEOUT_CYCLES = c_timeout_default,
  localparam int unsigned BEATS          = 128 / BUS_W,
  localparam int unsigned LL_W           = CNT_W + $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  n_blocks_i,
  input  logic [1:0]        key_mode_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] sink_base_i,
  output logic [ADDR_W-1:0] src_base_o,
  output logic [ADDR_W-1:0] sink_base_o,
  output logic [LL_W-1:0]   line_length_o,
  output logic              src_req_start_o,
  output logic              sink_req_start_o,
  input  logic              src_ready_start_i,
  input  logic              sink_ready_start_i,
  input  logic              eng_load_done_i,
  input  logic              sink_block_done_i,
  output logic              eng_clear_o,
  output logic              eng_start_o,
  output logic              eng_enable_o,
  output logic [3:0]        eng_round_o,
  output logic              eng_last_round_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  blocks_done_o,
  output logic              done_o,
  output logic              err_o
);

  generate
    if (BUS_W == 0 || (128 % BUS_W) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("aes_multiblock_fsm: BUS_W must divide 128 and TIMEOUT_CYCLES must be >= 2");
    end
  endgenerate

  aes_mb_state_t     state_q, state_d;
  logic [CNT_W-1:0]  n_blocks_q;
  logic [CNT_W-1:0]  blocks_done_q;
  logic [3:0]        nr_q;
  logic [ADDR_W-1:0] src_base_q;
  logic [ADDR_W-1:0] sink_base_q;
  logic [LL_W-1:0]   line_len_q;

  logic              w_working;
  logic              w_round_last;
  logic [3:0]        w_round;
  logic              w_start_accept;
  logic              w_blk_last;

  assign w_working      = (state_q == WORKING);
  assign w_start_accept = (state_q == IDLE) && start_i;
  assign w_blk_last     = (blocks_done_q == n_blocks_q - CNT_W'(1));

  aes_round_counter u_round_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .en_i    (w_working),
    .nr_i    (nr_q),
    .round_o (w_round),
    .last_o  (w_round_last)
  );

`ifdef AES_MBFSM_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] c_wd_limit = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            err_q;
  logic            w_wd_active;
  logic            w_timeout_fire;

  assign w_wd_active = (state_q == STARTING) || (state_q == LOAD) || (state_q == DRAIN);
`endif

  always_comb begin
    state_d          = state_q;
    src_req_start_o  = 1'b0;
    sink_req_start_o = 1'b0;
    eng_clear_o      = 1'b0;
    eng_start_o      = 1'b0;
    eng_enable_o     = 1'b0;
    done_o           = 1'b0;

    case (state_q)
      IDLE: begin
        eng_clear_o = 1'b1;
        if (start_i) begin
          state_d = (n_blocks_i != '0) ? STARTING : FINISHED;
        end
      end
      STARTING: begin
        src_req_start_o  = 1'b1;
        sink_req_start_o = 1'b1;
        if (src_ready_start_i && sink_ready_start_i) begin
          eng_start_o = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        eng_enable_o = 1'b1;
        if (eng_load_done_i) begin
          state_d = WORKING;
        end
      end
      WORKING: begin
        eng_enable_o = 1'b1;
        if (w_round_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        eng_enable_o = 1'b1;
        if (sink_block_done_i) begin
          state_d = w_blk_last ? FINISHED : LOAD;
        end
      end
      FINISHED: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef AES_MBFSM_TIMEOUT_EN
    // A handshake arriving on the limit cycle still wins over the watchdog.
    w_timeout_fire = 1'b0;
    if (w_wd_active && (wdog_q == c_wd_limit) && (state_d == state_q)) begin
      state_d        = FINISHED;
      w_timeout_fire = 1'b1;
    end
    wdog_d = (w_wd_active && (state_d == state_q)) ? wdog_q + WD_W'(1) : '0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      n_blocks_q    <= '0;
      blocks_done_q <= '0;
      nr_q          <= 4'd0;
      src_base_q    <= '0;
      sink_base_q   <= '0;
      line_len_q    <= '0;
    end else if (clear) begin
      // Job configuration is left in place; only progress state is dropped.
      state_q       <= IDLE;
      blocks_done_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_start_accept) begin
        blocks_done_q <= '0;
        if (n_blocks_i != '0) begin
          n_blocks_q  <= n_blocks_i;
          nr_q        <= nr_for_mode(key_mode_i);
          src_base_q  <= src_base_i;
          sink_base_q <= sink_base_i;
          line_len_q  <= LL_W'(n_blocks_i) << $clog2(BEATS);
        end
      end else if ((state_q == DRAIN) && sink_block_done_i) begin
        blocks_done_q <= blocks_done_q + CNT_W'(1);
      end
    end
  end

`ifdef AES_MBFSM_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else if (clear) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      if (w_start_accept) begin
        err_q <= 1'b0;
      end else if (w_timeout_fire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign src_base_o       = src_base_q;
  assign sink_base_o      = sink_base_q;
  assign line_length_o    = line_len_q;
  assign eng_round_o      = w_round;
  assign eng_last_round_o = w_round_last;
  assign busy_o           = (state_q != IDLE);
  assign blocks_done_o    = blocks_done_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_multiblock_fsm.sv
// ============================================================================
// Module : tb_aes_multiblock_fsm
// Brief  : Self-checking bench for aes_multiblock_fsm against a schedule model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_multiblock_fsm;

  localparam int BUS_W = 32;
  localparam int CNT_W = 16;
  localparam int ADDR_W = 32;
  localparam int TO = 16;
  localparam int LL_W = CNT_W + $clog2(128 / BUS_W);

  localparam int PH_IDLE = 0, PH_START = 1, PH_LOAD = 2, PH_WORK = 3, PH_DRAIN = 4, PH_FIN = 5;

  logic clk = 1'b0;
  logic reset, clear, start_i;
  logic [CNT_W-1:0]  n_blocks_i;
  logic [1:0]        key_mode_i;
  logic [ADDR_W-1:0] src_base_i, sink_base_i, src_base_o, sink_base_o;
  logic [LL_W-1:0]   line_length_o;
  logic src_req_start_o, sink_req_start_o, src_ready_start_i, sink_ready_start_i;
  logic eng_load_done_i, sink_block_done_i;
  logic eng_clear_o, eng_start_o, eng_enable_o, eng_last_round_o, busy_o, done_o, err_o;
  logic [3:0]        eng_round_o;
  logic [CNT_W-1:0]  blocks_done_o;

  aes_multiblock_fsm #(
    .BUS_W(BUS_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .start_i(start_i),
    .n_blocks_i(n_blocks_i), .key_mode_i(key_mode_i),
    .src_base_i(src_base_i), .sink_base_i(sink_base_i),
    .src_base_o(src_base_o), .sink_base_o(sink_base_o), .line_length_o(line_length_o),
    .src_req_start_o(src_req_start_o), .sink_req_start_o(sink_req_start_o),
    .src_ready_start_i(src_ready_start_i), .sink_ready_start_i(sink_ready_start_i),
    .eng_load_done_i(eng_load_done_i), .sink_block_done_i(sink_block_done_i),
    .eng_clear_o(eng_clear_o), .eng_start_o(eng_start_o), .eng_enable_o(eng_enable_o),
    .eng_round_o(eng_round_o), .eng_last_round_o(eng_last_round_o),
    .busy_o(busy_o), .blocks_done_o(blocks_done_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // One entry per clock cycle: inputs to apply and outputs expected.
  typedef struct {
    int      ph;
    bit      st;
    bit [15:0] nb;
    bit [1:0]  km;
    bit [31:0] sb, kb;
    bit      srdy, krdy, lp, sp;
    bit      busy, req, est, en, eclr, last, done, err;
    int      rnd, bdone;
  } ent_t;

  ent_t sched[$];
  int   total = 0;
  int   bad = 0;
  int   cur_bdone = 0;
  bit   exp_err = 1'b0;
  logic [63:0] exp_src = '0, exp_sink = '0, exp_ll = '0;

  task automatic chk(input string tag, input int idx, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  function automatic ent_t noise(input int ph, input int bd);
    ent_t e;
    e.ph = ph; e.st = ($urandom_range(3) == 0); e.nb = 16'($urandom); e.km = 2'($urandom);
    e.sb = $urandom; e.kb = $urandom;
    e.srdy = 1'($urandom); e.krdy = 1'($urandom); e.lp = 1'($urandom); e.sp = 1'($urandom);
    e.busy = 1'b1; e.req = 1'b0; e.est = 1'b0; e.en = 1'b0; e.eclr = 1'b0;
    e.last = 1'b0; e.done = 1'b0; e.err = 1'b0; e.rnd = 0; e.bdone = bd;
    return e;
  endfunction

  task automatic drive(input ent_t e);
    start_i = e.st; n_blocks_i = e.nb; key_mode_i = e.km;
    src_base_i = e.sb; sink_base_i = e.kb;
    src_ready_start_i = e.srdy; sink_ready_start_i = e.krdy;
    eng_load_done_i = e.lp; sink_block_done_i = e.sp;
  endtask

  task automatic drive_idle();
    start_i = 0; n_blocks_i = '0; key_mode_i = '0; src_base_i = '0; sink_base_i = '0;
    src_ready_start_i = 0; sink_ready_start_i = 0; eng_load_done_i = 0; sink_block_done_i = 0;
    clear = 0;
  endtask

  // Expected cycle-by-cycle schedule of a job derived from the block's rules.
  task automatic build(input int n, input int mode, input int rdly, input bit src_first,
                       input int lmin, input int lmax, input int smin, input int smax, input bit wd);
    ent_t e;
    int nr = (mode == 3) ? 10 : 10 + 2 * mode;
    int fin_bd = n;
    bit timed_out = 0;
    sched.delete();
    e = noise(PH_IDLE, cur_bdone);
    e.st = 1; e.nb = 16'(n); e.km = 2'(mode); e.busy = 0; e.eclr = 1; e.err = exp_err;
    sched.push_back(e);
    if (n != 0) begin
      exp_src = 64'(e.sb); exp_sink = 64'(e.kb); exp_ll = 64'(n * 4);
    end
    if (n == 0) begin
      e = noise(PH_FIN, 0); e.done = 1; sched.push_back(e);
      fin_bd = 0;
    end else begin
      for (int i = 0; i <= rdly; i++) begin
        e = noise(PH_START, 0); e.req = 1;
        if (i < rdly) begin
          if (src_first) begin e.srdy = 1; e.krdy = 0; end
          else begin e.srdy = 0; end
        end else begin
          e.srdy = 1; e.krdy = 1; e.est = 1;
        end
        sched.push_back(e);
      end
      for (int b = 0; b < n && !timed_out; b++) begin
        int ld = $urandom_range(lmax, lmin);
        int sd = $urandom_range(smax, smin);
        for (int i = 0; i <= ld; i++) begin
          e = noise(PH_LOAD, b); e.en = 1; e.lp = (i == ld); sched.push_back(e);
        end
        for (int r = 0; r <= nr; r++) begin
          e = noise(PH_WORK, b); e.en = 1; e.rnd = r; e.last = (r == nr); sched.push_back(e);
        end
        if (wd) begin
          for (int i = 0; i < TO; i++) begin
            e = noise(PH_DRAIN, b); e.en = 1; e.sp = 0; sched.push_back(e);
          end
          e = noise(PH_FIN, b); e.done = 1; e.err = 1; sched.push_back(e);
          timed_out = 1; fin_bd = b;
        end else begin
          for (int i = 0; i <= sd; i++) begin
            e = noise(PH_DRAIN, b); e.en = 1; e.sp = (i == sd); sched.push_back(e);
          end
        end
      end
      if (!timed_out) begin
        e = noise(PH_FIN, n); e.done = 1; sched.push_back(e);
      end
    end
    exp_err = timed_out;
    e = noise(PH_IDLE, fin_bd); e.st = 0; e.busy = 0; e.eclr = 1; e.err = exp_err;
    sched.push_back(e);
    cur_bdone = fin_bd;
  endtask

  task automatic check_entry(input ent_t e, input int k);
    chk("busy", k, 64'(busy_o), 64'(e.busy));
    chk("src_req", k, 64'(src_req_start_o), 64'(e.req));
    chk("sink_req", k, 64'(sink_req_start_o), 64'(e.req));
    chk("eng_start", k, 64'(eng_start_o), 64'(e.est));
    chk("eng_enable", k, 64'(eng_enable_o), 64'(e.en));
    chk("eng_clear", k, 64'(eng_clear_o), 64'(e.eclr));
    chk("round", k, 64'(eng_round_o), 64'(e.rnd));
    chk("last_round", k, 64'(eng_last_round_o), 64'(e.last));
    chk("done", k, 64'(done_o), 64'(e.done));
    chk("err", k, 64'(err_o), 64'(e.err));
    chk("blocks_done", k, 64'(blocks_done_o), 64'(e.bdone));
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, 0, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 0, 64'(done_o), 64'd0);
    chk({tag, "_src_req"}, 0, 64'(src_req_start_o), 64'd0);
    chk({tag, "_sink_req"}, 0, 64'(sink_req_start_o), 64'd0);
    chk({tag, "_eng_clear"}, 0, 64'(eng_clear_o), 64'd1);
    chk({tag, "_blocks_done"}, 0, 64'(blocks_done_o), 64'd0);
    chk({tag, "_err"}, 0, 64'(err_o), 64'd0);
  endtask

  // abort: 0 none, 1 async reset at round 5 of block 0, 2 clear in first DRAIN cycle.
  task automatic run(input int abort);
    bit cleared = 0;
    foreach (sched[k]) begin
      @(posedge clk); #1;
      drive(sched[k]);
      if (abort == 2 && sched[k].ph == PH_DRAIN) begin
        clear = 1; cleared = 1;
      end
      @(negedge clk);
      check_entry(sched[k], k);
      if (abort == 1 && sched[k].ph == PH_WORK && sched[k].rnd == 5) begin
        #2 reset = 1;
        #1 check_quiet("async_reset");
        chk("async_reset_enable", 0, 64'(eng_enable_o), 64'd0);
        chk("async_reset_round", 0, 64'(eng_round_o), 64'd0);
        @(posedge clk); #1;
        reset = 0; drive_idle();
        @(negedge clk);
        check_quiet("after_reset");
        cur_bdone = 0; exp_err = 0; exp_src = '0; exp_sink = '0; exp_ll = '0;
        return;
      end
      if (cleared) begin
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        check_quiet("after_clear");
        cur_bdone = 0; exp_err = 0;
        return;
      end
    end
    chk("line_length", 0, 64'(line_length_o), exp_ll);
    chk("src_base", 0, 64'(src_base_o), exp_src);
    chk("sink_base", 0, 64'(sink_base_o), exp_sink);
  endtask

  initial begin
    reset = 1;
    drive_idle();
    @(negedge clk);
    check_quiet("reset");
    chk("reset_enable", 0, 64'(eng_enable_o), 64'd0);
    chk("reset_start", 0, 64'(eng_start_o), 64'd0);
    chk("reset_round", 0, 64'(eng_round_o), 64'd0);
    chk("reset_last", 0, 64'(eng_last_round_o), 64'd0);
    chk("reset_line_length", 0, 64'(line_length_o), 64'd0);
    chk("reset_src_base", 0, 64'(src_base_o), 64'd0);
    chk("reset_sink_base", 0, 64'(sink_base_o), 64'd0);
    #2 reset = 0;

    // Single AES-128 block, immediate handshakes: done on the 15th cycle.
    build(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("latency_1blk_aes128", 0, 64'(sched.size() - 2), 64'd15);
    run(0);
    // Handshakes one cycle after entering LOAD / DRAIN.
    build(1, 0, 0, 0, 1, 1, 1, 1, 0); run(0);
    // Three AES-256 blocks: 4 beats/block gives a line length of 12.
    build(3, 2, 0, 0, 0, 0, 0, 0, 0); run(0);
    chk("line_length_3blk", 0, 64'(line_length_o), 64'd12);
    // Sink not ready for 5 cycles while the source is.
    build(2, 1, 5, 1, 0, 2, 0, 2, 0); run(0);
    // Empty job: straight to FINISHED, no streamer requests.
    build(0, 0, 0, 0, 0, 0, 0, 0, 0); run(0);
    for (int j = 0; j < 6; j++) begin
      build($urandom_range(4, 1), $urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom),
            0, 3, 0, 3, 0);
      run(0);
    end
    build(2, 0, 1, 0, 0, 1, 0, 1, 0); run(1);
    build(1, 1, 0, 0, 0, 1, 0, 1, 0); run(0);
    build(2, 1, 0, 0, 0, 1, 0, 1, 0); run(2);
    build(2, 2, 1, 1, 0, 2, 0, 2, 0); run(0);
`ifdef AES_MBFSM_TIMEOUT_EN
    build(1, 0, 0, 0, 0, 0, 0, 0, 1); run(0);
    build(1, 0, 0, 0, 0, 1, 0, 1, 0); run(0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
